// File: rtl/reg_file_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_if
// Description : Controller-to-register-file request/response bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  WrEn;
    logic                  RdEn;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] WrData;
    logic [DATA_WIDTH-1:0] RdData;
    logic                  RdData_Valid;

    modport master (
        output WrEn, RdEn, Address, WrData,
        input  RdData, RdData_Valid
    );

    modport slave (
        input  WrEn, RdEn, Address, WrData,
        output RdData, RdData_Valid
    );
endinterface
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : Flop-based register file with registered reads and continuous
//               export of the four reserved configuration registers.
//               Optional macro REGFILE_RD_ERR_EN adds the RD_ERR output.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  wire logic                  CLK,
    input  wire logic                  RST,
    reg_file_if.slave                  bus,
    output logic      [DATA_WIDTH-1:0] REG0,
    output logic      [DATA_WIDTH-1:0] REG1,
    output logic      [DATA_WIDTH-1:0] REG2,
    output logic      [DATA_WIDTH-1:0] REG3
`ifdef REGFILE_RD_ERR_EN
    ,
    output logic                       RD_ERR
`endif
);

    localparam int              c_DEPTH     = 2**ADDR_WIDTH;
    // Parity enabled, even parity, prescale 32
    localparam [DATA_WIDTH-1:0] c_UART_RST  = DATA_WIDTH'(8'h81);
    localparam [DATA_WIDTH-1:0] c_DIV_RST   = DATA_WIDTH'(8'h20);

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  w_wr;
    logic                  w_rd;

    // A simultaneous request is illegal and must do nothing at all
    assign w_wr = bus.WrEn & ~bus.RdEn;
    assign w_rd = bus.RdEn & ~bus.WrEn;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_mem[2] <= c_UART_RST;
            r_mem[3] <= c_DIV_RST;
        end else if (w_wr) begin
            r_mem[bus.Address] <= bus.WrData;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd;
            if (w_rd) begin
                r_rd_data <= r_mem[bus.Address];
            end
        end
    end

`ifdef REGFILE_RD_ERR_EN
    logic r_rd_err;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rd_err <= 1'b0;
        end else begin
            r_rd_err <= bus.WrEn & bus.RdEn;
        end
    end

    assign RD_ERR = r_rd_err;
`endif

    assign bus.RdData       = r_rd_data;
    assign bus.RdData_Valid = r_rd_valid;
    assign REG0             = r_mem[0];
    assign REG1             = r_mem[1];
    assign REG2             = r_mem[2];
    assign REG3             = r_mem[3];

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file
// Description : Self-checking bench for reg_file against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    logic       clk;
    logic       rst_n;
    logic [7:0] reg0, reg1, reg2, reg3;
`ifdef REGFILE_RD_ERR_EN
    logic       rd_err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: register contents plus last expected read response
    logic [7:0] mdl_mem [16];
    logic [7:0] mdl_rd;
    logic       mdl_valid;
    logic       mdl_err;

    reg_file_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    reg_file #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .CLK    (clk),
        .RST    (rst_n),
        .bus    (bus.slave),
        .REG0   (reg0),
        .REG1   (reg1),
        .REG2   (reg2),
        .REG3   (reg3)
`ifdef REGFILE_RD_ERR_EN
        ,
        .RD_ERR (rd_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdl_mem[i] = 8'h00;
        mdl_mem[2] = 8'h81;
        mdl_mem[3] = 8'h20;
        mdl_rd     = 8'h00;
        mdl_valid  = 1'b0;
        mdl_err    = 1'b0;
    endtask

    // Drive one request, step one edge, advance the model
    task automatic cyc(input logic wr, input logic rd, input logic [3:0] a, input logic [7:0] d);
        bus.WrEn    = wr;
        bus.RdEn    = rd;
        bus.Address = a;
        bus.WrData  = d;
        @(posedge clk);
        #1;
        mdl_valid = rd && !wr;
        if (mdl_valid) mdl_rd = mdl_mem[a];
        if (wr && !rd) mdl_mem[a] = d;
        mdl_err = wr && rd;
    endtask

    task automatic test_reset();
        bus.WrEn = 0; bus.RdEn = 0; bus.Address = 0; bus.WrData = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (reg0 !== 8'h00 || reg1 !== 8'h00 || reg2 !== 8'h81 || reg3 !== 8'h20) begin
            errors++;
            $display("FAIL reset_regs: got %h %h %h %h, expected 00 00 81 20", reg0, reg1, reg2, reg3);
        end
        checks++;
        if (bus.RdData !== 8'h00 || bus.RdData_Valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd: got data %h valid %b, expected 00 0", bus.RdData, bus.RdData_Valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 4'(i), 8'h00);
            checks++;
            if (bus.RdData !== mdl_rd || bus.RdData_Valid !== 1'b1) begin
                errors++;
                $display("FAIL reset_read[%0d]: got %h/%b, expected %h/1", i, bus.RdData, bus.RdData_Valid, mdl_rd);
            end
        end
        cyc(1'b0, 1'b0, 4'd0, 8'h00);
    endtask

    task automatic test_write_read();
        cyc(1'b1, 1'b0, 4'd7, 8'h5A);
        checks++;
        if (bus.RdData_Valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_valid: got %b, expected 0", bus.RdData_Valid);
        end
        cyc(1'b0, 1'b1, 4'd7, 8'h00);
        checks++;
        if (bus.RdData !== 8'h5A || bus.RdData_Valid !== 1'b1) begin
            errors++;
            $display("FAIL wr_rd: got %h/%b, expected 5a/1", bus.RdData, bus.RdData_Valid);
        end
        cyc(1'b0, 1'b0, 4'd0, 8'h00);
        checks++;
        if (bus.RdData !== 8'h5A || bus.RdData_Valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got %h/%b, expected 5a/0", bus.RdData, bus.RdData_Valid);
        end
    endtask

    task automatic test_held_read();
        logic [7:0] exp_d [3];
        logic [3:0] adr   [3];
        exp_d[0] = 8'h81; exp_d[1] = 8'h20; exp_d[2] = 8'h00;
        adr[0] = 4'd2; adr[1] = 4'd3; adr[2] = 4'd0;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1, adr[k], 8'h00);
            checks++;
            if (bus.RdData !== exp_d[k] || bus.RdData_Valid !== 1'b1) begin
                errors++;
                $display("FAIL held_read[%0d]: got %h/%b, expected %h/1", k, bus.RdData, bus.RdData_Valid, exp_d[k]);
            end
        end
        cyc(1'b0, 1'b0, 4'd0, 8'h00);
        checks++;
        if (bus.RdData_Valid !== 1'b0) begin
            errors++;
            $display("FAIL held_end: valid %b, expected 0", bus.RdData_Valid);
        end
    endtask

    task automatic test_operand_export();
        cyc(1'b1, 1'b0, 4'd0, 8'h12);
        checks++;
        if (reg0 !== 8'h12 || reg2 !== 8'h81 || reg3 !== 8'h20) begin
            errors++;
            $display("FAIL export_a: got %h %h %h, expected 12 81 20", reg0, reg2, reg3);
        end
        cyc(1'b1, 1'b0, 4'd1, 8'h34);
        checks++;
        if (reg1 !== 8'h34 || reg0 !== 8'h12 || reg2 !== 8'h81 || reg3 !== 8'h20) begin
            errors++;
            $display("FAIL export_b: got %h %h %h %h, expected 12 34 81 20", reg0, reg1, reg2, reg3);
        end
    endtask

    task automatic test_conflict();
        logic [7:0] held;
        held = mdl_rd;
        cyc(1'b1, 1'b1, 4'd5, 8'hFF);
        checks++;
        if (bus.RdData_Valid !== 1'b0 || bus.RdData !== held) begin
            errors++;
            $display("FAIL conflict_rd: got %h/%b, expected %h/0", bus.RdData, bus.RdData_Valid, held);
        end
`ifdef REGFILE_RD_ERR_EN
        checks++;
        if (rd_err !== 1'b1) begin
            errors++;
            $display("FAIL conflict_err: got %b, expected 1", rd_err);
        end
`endif
        cyc(1'b0, 1'b1, 4'd5, 8'h00);
        checks++;
        if (bus.RdData !== 8'h00 || bus.RdData_Valid !== 1'b1) begin
            errors++;
            $display("FAIL conflict_mem: got %h/%b, expected 00/1", bus.RdData, bus.RdData_Valid);
        end
`ifdef REGFILE_RD_ERR_EN
        checks++;
        if (rd_err !== 1'b0) begin
            errors++;
            $display("FAIL conflict_err_clr: got %b, expected 0", rd_err);
        end
`endif
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 1'b0, 4'd3, 8'hAA);
        checks++;
        if (reg3 !== 8'hAA) begin
            errors++;
            $display("FAIL mid_wr: REG3 %h, expected aa", reg3);
        end
        cyc(1'b0, 1'b1, 4'd3, 8'h00);
        checks++;
        if (bus.RdData !== 8'hAA || bus.RdData_Valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_rd: got %h/%b, expected aa/1", bus.RdData, bus.RdData_Valid);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (bus.RdData_Valid !== 1'b0 || bus.RdData !== 8'h00 || reg3 !== 8'h20 || reg0 !== 8'h00) begin
            errors++;
            $display("FAIL mid_rst: got %h/%b REG3 %h REG0 %h, expected 00/0 20 00",
                     bus.RdData, bus.RdData_Valid, reg3, reg0);
        end
        bus.RdEn = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, 4'd3, 8'h00);
        checks++;
        if (bus.RdData !== 8'h20 || bus.RdData_Valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_after: got %h/%b, expected 20/1", bus.RdData, bus.RdData_Valid);
        end
    endtask

    task automatic test_random();
        int sel;
        logic wr, rd;
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            wr  = (sel < 4) || (sel == 9);
            rd  = (sel >= 4 && sel < 8) || (sel == 9);
            cyc(wr, rd, 4'($urandom_range(0, 15)), 8'($urandom));
            checks++;
            if (bus.RdData !== mdl_rd || bus.RdData_Valid !== mdl_valid ||
                reg0 !== mdl_mem[0] || reg1 !== mdl_mem[1] ||
                reg2 !== mdl_mem[2] || reg3 !== mdl_mem[3]) begin
                errors++;
                $display("FAIL random[%0d]: rd %h/%b regs %h %h %h %h, expected %h/%b %h %h %h %h",
                         n, bus.RdData, bus.RdData_Valid, reg0, reg1, reg2, reg3,
                         mdl_rd, mdl_valid, mdl_mem[0], mdl_mem[1], mdl_mem[2], mdl_mem[3]);
            end
`ifdef REGFILE_RD_ERR_EN
            checks++;
            if (rd_err !== mdl_err) begin
                errors++;
                $display("FAIL random_err[%0d]: got %b, expected %b", n, rd_err, mdl_err);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_held_read();
        test_operand_export();
        test_conflict();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
